// File: rtl/fpu_unpack.sv
// fpu_unpack: splits an IEEE-754 single-precision operand into sign, unbiased
// exponent and mantissa. It also raises one class flag for NaN, infinity or zero.
// The operand is taken on an in_valid/in_ready handshake. The result is held
// until the out_valid/out_ready handshake completes.
// Optional feature macro: FPU_UNPACK_NORM_EN. When it is defined, denormal
// operands are shifted left one bit per cycle until the hidden bit is set.
// The default build passes denormals through unchanged.
module fpu_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        z_s,
  output logic [9:0]  z_e,
  output logic [26:0] z_m,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UNPACK    = 2'd1,
    NORMALISE = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Operand class encoding used between the classifier and the datapath
  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_ZERO   = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] a_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        z_s_r;
  logic [9:0]  z_e_r;
  logic [26:0] z_m_r;
  logic        is_nan_r;
  logic        is_inf_r;
  logic        is_zero_r;

  logic [7:0]  exp_s;
  logic [22:0] frac_s;
  cls_t        cls_s;
  logic [9:0]  unp_e_s;
  logic [26:0] unp_m_s;
  logic        accept_s;

  // Classify an operand from its exponent and fraction fields
  function automatic cls_t classify(input logic [7:0] e, input logic [22:0] f);
    cls_t c;
    if (e == 8'hFF) begin
      c = (f != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (e == 8'h00) begin
      c = (f != 23'd0) ? CLS_DENORM : CLS_ZERO;
    end else begin
      c = CLS_NORMAL;
    end
    return c;
  endfunction

  assign exp_s    = a_r[30:23];
  assign frac_s   = a_r[22:0];
  assign cls_s    = classify(exp_s, frac_s);
  assign accept_s = in_valid && in_ready_r;

  // Unpacked exponent and mantissa for each operand class
  always_comb begin
    unp_e_s = 10'h000;
    unp_m_s = 27'd0;
    case (cls_s)
      CLS_NAN: begin
        unp_e_s = 10'h080;
        unp_m_s = {3'b000, 1'b1, frac_s};
      end
      CLS_INF: begin
        unp_e_s = 10'h080;
        unp_m_s = 27'd0;
      end
      CLS_ZERO: begin
        unp_e_s = 10'h382;
        unp_m_s = 27'd0;
      end
      CLS_DENORM: begin
        unp_e_s = 10'h382;
        unp_m_s = {3'b000, 1'b0, frac_s};
      end
      CLS_NORMAL: begin
        unp_e_s = {2'b00, exp_s} - 10'd127;
        unp_m_s = {3'b000, 1'b1, frac_s};
      end
      default: begin
        unp_e_s = 10'h000;
        unp_m_s = 27'd0;
      end
    endcase
  end

  // Next-state logic of the handshake / normalisation FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = UNPACK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      UNPACK: begin
`ifdef FPU_UNPACK_NORM_EN
        if (cls_s == CLS_DENORM) begin
          state_nxt_s = NORMALISE;
        end else begin
          state_nxt_s = DONE;
        end
`else
        state_nxt_s = DONE;
`endif
      end
      NORMALISE: begin
`ifdef FPU_UNPACK_NORM_EN
        // The shift on this edge moves bit 22 into the hidden-bit position
        if (z_m_r[22]) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = NORMALISE;
        end
`else
        state_nxt_s = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and the registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture and the result datapath (load, normalise, hold)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= 32'd0;
      z_s_r     <= 1'b0;
      z_e_r     <= 10'h000;
      z_m_r     <= 27'd0;
      is_nan_r  <= 1'b0;
      is_inf_r  <= 1'b0;
      is_zero_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && accept_s) begin
        a_r <= a_in;
      end
      case (state_r)
        UNPACK: begin
          z_s_r     <= a_r[31];
          z_e_r     <= unp_e_s;
          z_m_r     <= unp_m_s;
          is_nan_r  <= (cls_s == CLS_NAN);
          is_inf_r  <= (cls_s == CLS_INF);
          is_zero_r <= (cls_s == CLS_ZERO);
        end
        NORMALISE: begin
`ifdef FPU_UNPACK_NORM_EN
          z_m_r <= {z_m_r[25:0], 1'b0};
          z_e_r <= z_e_r - 10'd1;
`endif
        end
        default: begin
          // IDLE and DONE hold the last result
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign z_s       = z_s_r;
  assign z_e       = z_e_r;
  assign z_m       = z_m_r;
  assign is_nan    = is_nan_r;
  assign is_inf    = is_inf_r;
  assign is_zero   = is_zero_r;

endmodule

// File: tb/tb_fpu_unpack.sv
// Scoreboard testbench for fpu_unpack.
// The stimulus side pushes the expected results from a reference model. The
// monitor pops and compares them when out_valid is presented. It also checks
// the latency, that outputs stay stable in DONE, and the return to IDLE.
// Define FPU_UNPACK_NORM_EN for both bench and RTL to test the normalising build.
module tb_fpu_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        z_s;
  logic [9:0]  z_e;
  logic [26:0] z_m;
  logic        is_nan, is_inf, is_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;

  fpu_unpack dut (
    .clk(clk), .rst(rst), .a_in(a_in), .in_valid(in_valid), .in_ready(in_ready),
    .z_s(z_s), .z_e(z_e), .z_m(z_m), .is_nan(is_nan), .is_inf(is_inf),
    .is_zero(is_zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        s;
    logic [9:0]  e;
    logic [26:0] m;
    logic        nan, inf, zero;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model written from the field rules, using integer arithmetic
  function automatic exp_t model(input logic [31:0] a);
    exp_t r;
    int ex, fr, e, m;
    ex = int'(a[30:23]);
    fr = int'(a[22:0]);
    r.a = a; r.s = a[31]; r.nan = 1'b0; r.inf = 1'b0; r.zero = 1'b0;
    r.lat = 1; r.acc = 0; r.hold = 0;
    if (ex == 255) begin
      e = 128;
      if (fr != 0) begin m = fr + (1 << 23); r.nan = 1'b1; end
      else begin m = 0; r.inf = 1'b1; end
    end else if (ex == 0 && fr == 0) begin
      e = -126; m = 0; r.zero = 1'b1;
    end else if (ex == 0) begin
      e = -126; m = fr;
`ifdef FPU_UNPACK_NORM_EN
      while (m < (1 << 23)) begin
        m = m * 2; e = e - 1; r.lat = r.lat + 1;
      end
`endif
    end else begin
      e = ex - 127; m = fr + (1 << 23);
    end
    r.e = 10'(e);
    r.m = 27'(m);
    return r;
  endfunction

  // Issue one operand; junk in_valid is driven while the block is busy
  task automatic issue(input logic [31:0] a, input int hold);
    exp_t x;
    int t = 0;
    while (!in_ready) begin
      in_valid = 1'($urandom_range(0, 1));
      a_in = $urandom;
      @(negedge clk);
      t++;
      if (t > 300) begin
        chk("issue_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    x = model(a);
    x.acc = cyc + 1;
    x.hold = hold;
    q.push_back(x);
    n_issued++;
    in_valid = 1'b1;
    a_in = a;
    @(negedge clk);
    in_valid = 1'b0;
    a_in = $urandom;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: compare results on out_valid and pace out_ready
  exp_t cur;
  bit   seen = 1'b0;
  bit   expect_idle = 1'b0;
  int   hold_cnt = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      out_ready = 1'b0;
      seen = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            cur = q[0];
            seen = 1'b1;
            hold_cnt = cur.hold;
            chk($sformatf("latency a=%h", cur.a), 32'(cyc - cur.acc), 32'(cur.lat));
          end
        end
        if (seen) begin
          chk($sformatf("z_s a=%h", cur.a), 32'(z_s), 32'(cur.s));
          chk($sformatf("z_e a=%h", cur.a), 32'(z_e), 32'(cur.e));
          chk($sformatf("z_m a=%h", cur.a), 32'(z_m), 32'(cur.m));
          chk($sformatf("flags a=%h", cur.a), {29'd0, is_nan, is_inf, is_zero},
              {29'd0, cur.nan, cur.inf, cur.zero});
          if (hold_cnt == 0) begin
            out_ready = 1'b1;
            void'(q.pop_front());
            seen = 1'b0;
            expect_idle = 1'b1;
          end else begin
            out_ready = 1'b0;
            hold_cnt--;
          end
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [31:0] dir [10] = '{32'h3F800000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
                            32'h00000001, 32'h40000000, 32'h007FFFFF, 32'h7F7FFFFF,
                            32'h00800000, 32'h80400000};

  initial begin
    logic [31:0] a;
    logic [22:0] fr;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", {z_s, z_e, z_m}, 32'd0);
    chk("rst_flags", {29'd0, is_nan, is_inf, is_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // Directed vectors; the first result is held for three cycles
    for (int i = 0; i < 10; i++) issue(dir[i], (i == 0) ? 3 : $urandom_range(0, 3));

    // Randomized vectors biased towards the special exponents
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      fr = 23'($urandom) >> $urandom_range(0, 22);
      case ($urandom_range(0, 5))
        0: a[30:0] = {8'h00, (fr == 23'd0) ? 23'd1 : fr};
        1: a[30:0] = 31'd0;
        2: a[30:23] = 8'hFF;
        3: a[30:0] = {8'hFF, 23'd0};
        default: begin end
      endcase
      issue(a, $urandom_range(0, 3));
    end
    wait_empty();

    // Reset in the middle of an operation discards it
    mon_en = 1'b0;
    @(negedge clk);
    chk("pre_abort_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in = 32'h00000001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_z", {z_s, z_e, z_m}, 32'd0);
    chk("abort_flags", {29'd0, is_nan, is_inf, is_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rel_in_ready", 32'(in_ready), 32'd1);
    chk("abort_rel_out_valid", 32'(out_valid), 32'd0);
    mon_en = 1'b1;
    issue(32'h40000000, 1);
    wait_empty();
    chk("issued_count", 32'(n_issued), 32'd71);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_unpack.md
FPU_UNPACK -- requirements
Module: fpu_unpack

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port a_in, input, 32 bits: IEEE-754 single-precision operand.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a_in is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-006 The block SHALL have port z_s, output, 1 bit: sign.
REQ-007 The block SHALL have port z_e, output, 10 bits: unbiased exponent, two's complement.
REQ-008 The block SHALL have port z_m, output, 27 bits: mantissa; [23] hidden bit, [22:0] fraction, [26:24] always 0.
REQ-009 The block SHALL have ports is_nan, is_inf and is_zero, output, 1 bit each: operand class flags.
REQ-010 The block SHALL have port out_valid, output, 1 bit: z_* and flags are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-012 The block SHALL use FSM states IDLE, UNPACK, NORMALISE and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready registers a_in and moves to UNPACK (acceptance edge = edge 0).
REQ-014 UNPACK SHALL be one cycle; exp = a_in[30:23], frac = a_in[22:0], z_s = a_in[31] for all classes.
REQ-015 When exp==255 and frac!=0, the block SHALL output is_nan=1, z_e=10'h080 (+128), z_m={3'b0,1'b1,frac}.
REQ-016 When exp==255 and frac==0, the block SHALL output is_inf=1, z_e=10'h080, z_m=0.
REQ-017 When exp==0 and frac==0, the block SHALL output is_zero=1, z_e=10'h382 (-126), z_m=0; sign preserved; NORMALISE never entered.
REQ-018 For a normal operand, the block SHALL output z_e = exp-127 sign-extended to 10 bits and z_m={3'b0,1'b1,frac}.
REQ-019 For a denormal operand (exp==0, frac!=0), the block SHALL output z_e=10'h382 and z_m={3'b0,1'b0,frac}, with further handling per REQ-027/028.
REQ-020 UNPACK SHALL go to DONE except per REQ-028; out_valid rises after edge 1.
REQ-021 In DONE, out_valid SHALL be 1 and z_s, z_e, z_m and the flags SHALL hold stable until out_valid&&out_ready; that edge SHALL return the block to IDLE.
REQ-022 in_ready SHALL be 0 from acceptance until the IDLE return (no overlap); in_valid is ignored outside IDLE.
REQ-023 At most one flag SHALL be 1; all flags SHALL be 0 for normal and denormal operands.

Reset
REQ-024 While rst=1, the block SHALL force: state=IDLE, in_ready=0, out_valid=0, z_s=0, z_e=0, z_m=0, all flags 0.
REQ-025 Reset asserted in UNPACK, NORMALISE or DONE SHALL discard the operation with no output handshake.
REQ-026 On the first edge after rst falls, in_ready SHALL be 1.

Configuration
REQ-027 Without macro FPU_UNPACK_NORM_EN, denormals SHALL go straight to DONE with REQ-019 values, which repack bit-exactly; NORMALISE is unreachable.
REQ-028 With FPU_UNPACK_NORM_EN, denormals SHALL enter NORMALISE: one left shift of z_m and z_e-1 per cycle, entering DONE on the edge that brings a 1 into z_m[23].
REQ-029 With FPU_UNPACK_NORM_EN, a denormal needing k shifts (1..23) SHALL raise out_valid after edge 1+k; z_e reaches as low as 10'h36B (-149).

Verification
REQ-030 a_in=0x3F800000: z_s=0, z_e=0, z_m=0x0800000, flags 0, out_valid after edge 1.
REQ-031 a_in=0xFF800000: z_s=1, is_inf=1, z_e=0x080, z_m=0. a_in=0x7FC00000: is_nan=1, z_e=0x080, z_m=0x0C00000.
REQ-032 a_in=0x80000000: z_s=1, is_zero=1, z_e=0x382, z_m=0, out_valid after edge 1 in both configurations.
REQ-033 a_in=0x00000001, macro off: z_e=0x382, z_m=0x0000001 after edge 1; macro on: z_e=0x36B, z_m=0x0800000 after edge 24.
REQ-034 Hold out_ready=0 for 3 cycles in DONE: outputs stable, in_ready=0; raising out_ready gives IDLE next edge and in_ready=1.
REQ-035 Macro on, a_in=0x00000001, rst pulsed mid-NORMALISE: outputs zero immediately; after release, a_in=0x40000000 yields z_e=1, z_m=0x0800000.
